// File: rtl/regex_line_scheduler.sv
// regex_line_scheduler
//   Reads stored lines from a synchronous-read line RAM and feeds each one,
//   MSB first, one bit per cycle into the bit-serial regex engine. After
//   each line the engine's match flag is sampled. For a match, the 1-based
//   line number is queued on a ready/valid output stream.
//
// Parameters
//   WIDTH   bits per line
//   DEPTH   lines scanned per run
//   LINE_W  width of line index / line number / match counter (holds DEPTH)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, clears all state
//   start        begin a scan (sampled only while idle)
//   busy         high from the cycle after start is accepted until DONE
//   done         one-cycle pulse when the scan completes
//   mem_addr     line index to the RAM (held from FETCH through NEXT)
//   mem_data     RAM word, valid one cycle after mem_addr
//   eng_i        engine qualifier (high in SHIFT and SAMPLE)
//   eng_i_c      engine serial character bit
//   eng_o        engine match flag, captured on the edge leaving SAMPLE
//   match_valid  match record available
//   match_line   1-based line number of the record at the head
//   match_ready  consumer accepts the head record while match_valid is high
//   match_count  records pushed this run, saturating at all-ones
//
// Build option
//   REGEX_SCHED_MATCH_FIFO_EN  defined: 4-entry match FIFO
//                              undefined: single output register
module regex_line_scheduler #(
  parameter int unsigned WIDTH  = 21,
  parameter int unsigned DEPTH  = 10000,
  parameter int unsigned LINE_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [LINE_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_data,
  output logic              eng_i,
  output logic              eng_i_c,
  input  logic              eng_o,
  output logic              match_valid,
  output logic [LINE_W-1:0] match_line,
  input  logic              match_ready,
  output logic [LINE_W-1:0] match_count
);

  localparam int unsigned BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LINE_W-1:0] LAST_IDX = LINE_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_SAMPLE,
    S_PUSH,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LINE_W-1:0] idx_q, idx_d;
  logic [LINE_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic              ei_q, ei_d;
  logic              ec_q, ec_d;

  // Match storage handshake
  logic              full;   // storage cannot accept a push this cycle
  logic              push;
  logic              pop;

  assign pop  = match_valid && match_ready;
  assign push = (state_q == S_PUSH) && !full;

  // ------------------------------------------------------------------
  // Sequencer
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      bc_q    <= '0;
      ei_q    <= 1'b0;
      ec_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bc_q    <= bc_d;
      ei_q    <= ei_d;
      ec_q    <= ec_d;
    end
  end

  // eng_i / eng_i_c are registered: the value for the next state is
  // computed here, so the bit loaded on the LOAD edge is already on the
  // wire during SHIFT cycle 0, and SAMPLE sees eng_i=1 with eng_i_c=0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bc_d    = bc_q;
    ei_d    = 1'b0;
    ec_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        sh_d    = mem_data;
        bc_d    = BC_W'(WIDTH - 1);
        ei_d    = 1'b1;
        ec_d    = mem_data[WIDTH-1];
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        ei_d = 1'b1;
        if (bc_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          sh_d = {sh_q[WIDTH-2:0], 1'b0};
          ec_d = sh_q[WIDTH-2];
          bc_d = bc_q - 1'b1;
        end
      end
      S_SAMPLE: begin
        state_d = eng_o ? S_PUSH : S_NEXT;
      end
      S_PUSH: begin
        if (!full) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign mem_addr    = idx_q;
  assign eng_i       = ei_q;
  assign eng_i_c     = ec_q;
  assign match_count = cnt_q;

`ifdef REGEX_SCHED_MATCH_FIFO_EN
  // ------------------------------------------------------------------
  // 4-entry match FIFO
  // ------------------------------------------------------------------
  logic [LINE_W-1:0] slot_q [4];
  logic [LINE_W-1:0] slot_d [4];
  logic [1:0]        wp_q, wp_d;
  logic [1:0]        rp_q, rp_d;
  logic [2:0]        n_q, n_d;

  // A pop in the same cycle frees the slot the push lands in.
  assign full = (n_q == 3'd4) && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        slot_q[i] <= '0;
      end
      wp_q <= '0;
      rp_q <= '0;
      n_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        slot_q[i] <= slot_d[i];
      end
      wp_q <= wp_d;
      rp_q <= rp_d;
      n_q  <= n_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      slot_d[i] = slot_q[i];
    end
    wp_d = wp_q;
    rp_d = rp_q;
    n_d  = n_q;
    if (push) begin
      slot_d[wp_q] = idx_q + 1'b1;
      wp_d         = wp_q + 1'b1;
    end
    if (pop) begin
      rp_d = rp_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   n_d = n_q + 1'b1;
      2'b01:   n_d = n_q - 1'b1;
      default: n_d = n_q;
    endcase
  end

  assign match_valid = (n_q != '0);
  assign match_line  = slot_q[rp_q];
`else
  // ------------------------------------------------------------------
  // Single output register
  // ------------------------------------------------------------------
  logic              v_q, v_d;
  logic [LINE_W-1:0] line_q, line_d;

  // Pushing into the register being popped this cycle is allowed.
  assign full = v_q && !match_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q    <= 1'b0;
      line_q <= '0;
    end else begin
      v_q    <= v_d;
      line_q <= line_d;
    end
  end

  always_comb begin
    v_d    = v_q;
    line_d = line_q;
    if (push) begin
      v_d    = 1'b1;
      line_d = idx_q + 1'b1;
    end else if (pop) begin
      v_d = 1'b0;
    end
  end

  assign match_valid = v_q;
  assign match_line  = line_q;
`endif

endmodule

// File: tb/tb_regex_line_scheduler.sv
// Self-checking bench for regex_line_scheduler (DEPTH=4 lines of 21 bits).
// A small engine model matches a line when its last received bit is 1, so
// the expected records follow directly from the RAM contents.
module tb_regex_line_scheduler;

  localparam int W  = 21;
  localparam int D  = 4;
  localparam int LW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [LW-1:0] mem_addr;
  logic [W-1:0]  mem_data;
  logic          eng_i;
  logic          eng_i_c;
  logic          eng_o;
  logic          match_valid;
  logic [LW-1:0] match_line;
  logic          match_ready;
  logic [LW-1:0] match_count;

  regex_line_scheduler #(.WIDTH(W), .DEPTH(D), .LINE_W(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .eng_i       (eng_i),
    .eng_i_c     (eng_i_c),
    .eng_o       (eng_o),
    .match_valid (match_valid),
    .match_line  (match_line),
    .match_ready (match_ready),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  // Line RAM: synchronous read, 1-cycle latency
  logic [W-1:0] mem [D];
  always @(posedge clk) mem_data <= mem[mem_addr[1:0]];

  // Engine: collects the qualified bits, flags a match during the
  // terminator cycle when the last data bit was 1.
  int           ecnt;
  logic [W-1:0] acc;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ecnt <= 0;
      acc  <= '0;
    end else if (eng_i) begin
      if (ecnt < W) begin
        acc  <= {acc[W-2:0], eng_i_c};
        ecnt <= ecnt + 1;
      end
    end else begin
      ecnt <= 0;
    end
  end
  assign eng_o = eng_i && (ecnt == W) && acc[0];

  // Bookkeeping
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            pos = 0;
  int            model_line = 0;
  int            exp_m = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            start_cyc = 0;
  int            ready_mode = 0;   // 0: always ready, 1: random, 2: never
  bit            scanning = 0;
  bit            prev_hold = 0;
  bit            prev_done = 0;
  bit            start_req = 0;
  logic [LW-1:0] hold_line = '0;
  logic [W-1:0]  run_word = '0;
  logic [W-1:0]  last_word [D];
  int            exp_q [$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endfunction

  function automatic void fail_now(input string nm, input string detail);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", nm, detail, cyc);
  endfunction

  function automatic int sat(input int m);
    return (m > (1 << LW) - 1) ? (1 << LW) - 1 : m;
  endfunction

  // Cycles from the start edge to the done cycle when PUSH never stalls
  function automatic int exp_lat(input int m);
    return D * (W + 4) + m;
  endfunction

  // Per-cycle comparison against the model, sampled at the falling edge
  task automatic monitor();
    logic exp_c;
    if (reset) begin
      pos        = 0;
      scanning   = 0;
      prev_hold  = 0;
      prev_done  = 0;
      model_line = 0;
      exp_q.delete();
      return;
    end
    chk("busy", busy, scanning && !done);
    if (eng_i) begin
      if (pos < W && model_line < D) exp_c = mem[model_line][W-1-pos];
      else exp_c = 1'b0;
      chk("eng_i_c", eng_i_c, exp_c);
      chk("mem_addr", mem_addr, model_line);
      if (pos < W) run_word = {run_word[W-2:0], eng_i_c};
      pos++;
    end else begin
      chk("eng_i_c_idle", eng_i_c, 0);
      if (pos != 0) begin
        chk("run_len", pos, W + 1);
        if (model_line < D) last_word[model_line] = run_word;
        model_line++;
        pos = 0;
      end
    end
    if (prev_hold) begin
      chk("hold_valid", match_valid, 1);
      chk("hold_line", match_line, hold_line);
    end
    if (match_valid && match_ready) begin
      if (exp_q.size() == 0) fail_now("extra_record", $sformatf("got line %0d, none pending", match_line));
      else chk("match_line", match_line, exp_q.pop_front());
    end
    prev_hold = match_valid && !match_ready;
    hold_line = match_line;
    if (start && !scanning) begin
      scanning   = 1;
      start_cyc  = cyc + 1;
      model_line = 0;
      pos        = 0;
      exp_m      = 0;
      for (int i = 0; i < D; i++) begin
        if (mem[i][0]) begin
          exp_q.push_back(i + 1);
          exp_m++;
        end
      end
    end
    if (done) begin
      chk("done_pulse", prev_done, 0);
      chk("done_in_scan", scanning, 1);
      chk("match_count", match_count, sat(exp_m));
      chk("lines_scanned", model_line, D);
      done_cnt++;
      done_cyc = cyc;
      scanning = 0;
    end
    prev_done = done;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    start = start_req;
    case (ready_mode)
      0:       match_ready = 1'b1;
      1:       match_ready = 1'($urandom_range(0, 1));
      default: match_ready = 1'b0;
    endcase
    @(negedge clk);
    monitor();
  endtask

  task automatic start_scan();
    start_req = 1;
    tick();
    start_req = 0;
  endtask

  task automatic wait_done(input string nm, input bit chk_lat, input bit poke);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 3000) begin
      start_req = (poke && n == 12);
      tick();
      n++;
    end
    start_req = 0;
    if (done_cnt == d0) fail_now({nm, "_timeout"}, "no done within 3000 cycles");
    else if (chk_lat) chk({nm, "_latency"}, done_cyc - start_cyc, exp_lat(exp_m));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    ready_mode = 0;
    while ((exp_q.size() != 0 || match_valid) && n < 100) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
    chk({nm, "_valid_low"}, match_valid, 0);
  endtask

  task automatic chk_reset_values(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_eng_i"}, eng_i, 0);
    chk({nm, "_eng_i_c"}, eng_i_c, 0);
    chk({nm, "_match_valid"}, match_valid, 0);
    chk({nm, "_match_line"}, match_line, 0);
    chk({nm, "_match_count"}, match_count, 0);
  endtask

  initial begin
    int d;
    reset       = 1'b1;
    start       = 1'b0;
    match_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      mem[i]       = '0;
      last_word[i] = '0;
    end
    repeat (3) tick();
    chk_reset_values("reset");
    reset = 1'b0;
    tick();

    // Single match on line index 2, MSB-first bit order
    mem[0] = 21'h000002; mem[1] = 21'h000004; mem[2] = 21'h100001; mem[3] = 21'h000006;
    ready_mode = 0;
    start_scan();
    wait_done("single", 1, 0);
    chk("single_lat_lit", done_cyc - start_cyc, 101);
    chk("single_count_lit", match_count, 1);
    chk("bitorder_word", last_word[2], 21'h100001);
    drain("single");

    // No matches
    mem[0] = 21'h0AAAAA; mem[1] = 21'h155554; mem[2] = 21'h1FFFFE; mem[3] = 21'h000000;
    start_scan();
    wait_done("nomatch", 1, 0);
    chk("nomatch_lat_lit", done_cyc - start_cyc, 100);
    chk("nomatch_count_lit", match_count, 0);
    drain("nomatch");

    // Backpressure: every line matches, consumer not ready
    mem[0] = 21'h000001; mem[1] = 21'h1FFFFF; mem[2] = 21'h0F0F0F; mem[3] = 21'h123457;
    ready_mode = 2;
`ifdef REGEX_SCHED_MATCH_FIFO_EN
    start_scan();
    wait_done("bp_fifo", 1, 0);
    chk("bp_fifo_lat_lit", done_cyc - start_cyc, 104);
    chk("bp_fifo_count", match_count, 4);
    chk("bp_fifo_valid", match_valid, 1);
    chk("bp_fifo_head", match_line, 1);
`else
    d = done_cnt;
    start_scan();
    repeat (150) tick();
    chk("bp_reg_no_done", done_cnt, d);
    chk("bp_reg_addr", mem_addr, 1);
    chk("bp_reg_eng_i", eng_i, 0);
    chk("bp_reg_busy", busy, 1);
    chk("bp_reg_count", match_count, 1);
    chk("bp_reg_head", match_line, 1);
    ready_mode = 0;
    wait_done("bp_reg", 0, 0);
    chk("bp_reg_count_end", match_count, 4);
`endif
    drain("bp");

    // Reset during the first line's SHIFT discards a pending record
    mem[0] = 21'h000002; mem[1] = 21'h000004; mem[2] = 21'h000008; mem[3] = 21'h000003;
    ready_mode = 2;
    start_scan();
    wait_done("pre_reset", 1, 0);
    chk("pre_reset_valid", match_valid, 1);
    chk("pre_reset_line", match_line, 4);
    start_scan();
    repeat (12) tick();
    chk("mid_shift_eng_i", eng_i, 1);
    #2 reset = 1'b1;
    #1 chk_reset_values("async_reset");
    repeat (2) tick();
    reset = 1'b0;
    ready_mode = 0;
    tick();
    start_scan();
    wait_done("rescan", 1, 0);
    chk("rescan_count", match_count, 1);
    drain("rescan");

    // start pulsed mid-SHIFT is ignored
    start_scan();
    wait_done("busy_start", 1, 1);
    d = done_cnt;
    repeat (40) tick();
    chk("busy_start_one_done", done_cnt, d);
    drain("busy_start");

    // Random line contents, alternating steady and random backpressure
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < D; i++) mem[i] = W'($urandom);
      ready_mode = (r % 2 == 0) ? 0 : 1;
      start_scan();
      wait_done("rand", (r % 2 == 0), 0);
      drain("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
